// File: rtl/irq12_pkg.sv
// Shared constants and types for the 24-line interrupt controller.
package irq12_pkg;
  localparam int IRQ_MAX = 24;
  localparam int HALF_W  = 12;
  localparam int VEC_W   = 5;

  localparam logic [2:0] A_MASK_L = 3'd0;
  localparam logic [2:0] A_MASK_H = 3'd1;
  localparam logic [2:0] A_EDGE_L = 3'd2;
  localparam logic [2:0] A_EDGE_H = 3'd3;
  localparam logic [2:0] A_PEND_L = 3'd4;
  localparam logic [2:0] A_PEND_H = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} irq_state_e;
endpackage

// File: rtl/irq12_prio_enc.sv
// Combinational lowest-index-wins priority encoder over all 24 lines.
module irq12_prio_enc
  import irq12_pkg::*;
(
  input  logic [IRQ_MAX-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               any_valid
);
  always_comb begin
    idx       = '0;
    any_valid = |req;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = IRQ_MAX - 1; i >= 0; i--)
      if (req[i]) idx = VEC_W'(i);
  end
endmodule

// File: rtl/irq_controller12.sv
// Interrupt controller: per-line edge/level pending, mask, global enable,
// single outstanding request with ack/eoi handshake and no nesting.
module irq_controller12
  import irq12_pkg::*;
#(
  parameter int NUM_IRQ = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_MAX-1:0] irq,
  input  logic               cfg_write,
  input  logic [2:0]         cfg_addr,
  input  logic [HALF_W-1:0]  cfg_wdata,
  output logic [HALF_W-1:0]  cfg_rdata,
  output logic               int_req,
  output logic [VEC_W-1:0]   int_vector,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               in_service
);
  localparam logic [IRQ_MAX-1:0] LINE_EN = {IRQ_MAX{1'b1}} >> (IRQ_MAX - NUM_IRQ);

  logic [IRQ_MAX-1:0] mask, edge_en, epend, irq_q;
  logic [IRQ_MAX-1:0] pend, elig, pend_clr, ack_clr, epend_nxt;
  logic               ctrl_en;
  irq_state_e         state, state_nxt;
  logic [VEC_W-1:0]   enc_idx;
  logic               enc_any, vec_load;

  assign pend = (epend | (irq & ~edge_en)) & LINE_EN;
  assign elig = ctrl_en ? (pend & mask) : '0;

  always_comb begin
    pend_clr = '0;
    if (cfg_write && cfg_addr == A_PEND_L) pend_clr = {{HALF_W{1'b0}}, cfg_wdata};
    if (cfg_write && cfg_addr == A_PEND_H) pend_clr = {cfg_wdata, {HALF_W{1'b0}}};
  end

  // Accepting an edge request consumes its pending bit.
  assign ack_clr = (state == ST_REQ && int_ack && edge_en[int_vector])
                   ? (IRQ_MAX'(1) << int_vector) : '0;

  // New edges are ORed in after the clears so a same-cycle set wins.
  assign epend_nxt = (epend & ~(pend_clr | ack_clr)) | (irq & ~irq_q & edge_en & LINE_EN);

  irq12_prio_enc u_enc (
    .req       (elig),
    .idx       (enc_idx),
    .any_valid (enc_any)
  );

  always_comb begin
    state_nxt = state;
    vec_load  = 1'b0;
    case (state)
      ST_IDLE: if (enc_any) begin
        state_nxt = ST_REQ;
        vec_load  = 1'b1;
      end
      ST_REQ: begin
        if (int_ack)                 state_nxt = ST_SERVICE;
        else if (!elig[int_vector])  state_nxt = ST_IDLE;
      end
      ST_SERVICE: if (int_eoi) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask       <= '0;
      edge_en    <= '0;
      ctrl_en    <= 1'b0;
      epend      <= '0;
      irq_q      <= '0;
      state      <= ST_IDLE;
      int_vector <= '0;
    end else begin
      irq_q <= irq;
      epend <= epend_nxt;
      state <= state_nxt;
      if (vec_load) int_vector <= enc_idx;
      if (cfg_write) begin
        case (cfg_addr)
          A_MASK_L: mask    <= {mask[IRQ_MAX-1:HALF_W], cfg_wdata} & LINE_EN;
          A_MASK_H: mask    <= {cfg_wdata, mask[HALF_W-1:0]} & LINE_EN;
          A_EDGE_L: edge_en <= {edge_en[IRQ_MAX-1:HALF_W], cfg_wdata} & LINE_EN;
          A_EDGE_H: edge_en <= {cfg_wdata, edge_en[HALF_W-1:0]} & LINE_EN;
          A_CTRL:   ctrl_en <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign int_req    = (state == ST_REQ);
  assign in_service = (state == ST_SERVICE);

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_MASK_L: cfg_rdata = mask[HALF_W-1:0];
      A_MASK_H: cfg_rdata = mask[IRQ_MAX-1:HALF_W];
      A_EDGE_L: cfg_rdata = edge_en[HALF_W-1:0];
      A_EDGE_H: cfg_rdata = edge_en[IRQ_MAX-1:HALF_W];
      A_PEND_L: cfg_rdata = pend[HALF_W-1:0];
      A_PEND_H: cfg_rdata = pend[IRQ_MAX-1:HALF_W];
      A_CTRL:   cfg_rdata = {{(HALF_W-1){1'b0}}, ctrl_en};
      A_STATUS: cfg_rdata = {5'b0, in_service, int_req, int_vector};
      default:  cfg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_controller12.sv
// Directed scenarios plus random traffic against a per-line behavioural model.
module tb_irq_controller12;
  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] irq = '0;
  logic        cfg_write = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic [11:0] cfg_rdata;
  logic        int_req, in_service, int_ack = 1'b0, int_eoi = 1'b0;
  logic [4:0]  int_vector;

  int n_chk = 0, n_fail = 0;

  irq_controller12 #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .irq(irq), .cfg_write(cfg_write), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .int_req(int_req),
    .int_vector(int_vector), .int_ack(int_ack), .int_eoi(int_eoi),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Model: one entry per interrupt line, plus the handshake status.
  bit m_mask[24], m_edge[24], m_ep[24], m_prev[24];
  bit m_ctrl, m_req, m_svc;
  int m_vec;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend(int i);
    return (i < N) && (m_ep[i] || (irq[i] && !m_edge[i]));
  endfunction

  function automatic int m_read(logic [2:0] a);
    int r = 0;
    int b = a[0] ? 12 : 0;
    case (a)
      3'd0, 3'd1: for (int i = 0; i < 12; i++) if (m_mask[b+i]) r |= (1 << i);
      3'd2, 3'd3: for (int i = 0; i < 12; i++) if (m_edge[b+i]) r |= (1 << i);
      3'd4, 3'd5: for (int i = 0; i < 12; i++) if (m_pend(b+i)) r |= (1 << i);
      3'd6: r = int'(m_ctrl);
      default: r = m_vec | (int'(m_req) << 5) | (int'(m_svc) << 6);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 24; i++) begin
      m_mask[i] = 0; m_edge[i] = 0; m_ep[i] = 0; m_prev[i] = 0;
    end
    m_ctrl = 0; m_req = 0; m_svc = 0; m_vec = 0;
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic model_step();
    bit elig[24];
    bit ep_n[24];
    int first = -1;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 24; i++) begin
      elig[i] = m_pend(i) && m_mask[i] && m_ctrl;
      if (elig[i] && first < 0) first = i;
    end
    for (int i = 0; i < 24; i++) begin
      bit clr, set;
      clr = cfg_write && ((cfg_addr == 3'd4 && i < 12 && cfg_wdata[i % 12]) ||
                          (cfg_addr == 3'd5 && i >= 12 && cfg_wdata[i % 12]));
      if (m_req && int_ack && i == m_vec && m_edge[i]) clr = 1;
      set = (i < N) && irq[i] && !m_prev[i] && m_edge[i];
      ep_n[i] = set || (m_ep[i] && !clr);
    end
    if (m_svc) begin
      if (int_eoi) m_svc = 0;
    end else if (m_req) begin
      if (int_ack) begin m_req = 0; m_svc = 1; end
      else if (!elig[m_vec]) m_req = 0;
    end else if (first >= 0) begin
      m_req = 1; m_vec = first;
    end
    if (cfg_write) begin
      for (int i = 0; i < 12; i++) begin
        case (cfg_addr)
          3'd0: m_mask[i]    = (i < N) && cfg_wdata[i];
          3'd1: m_mask[i+12] = (i + 12 < N) && cfg_wdata[i];
          3'd2: m_edge[i]    = (i < N) && cfg_wdata[i];
          3'd3: m_edge[i+12] = (i + 12 < N) && cfg_wdata[i];
          default: ;
        endcase
      end
      if (cfg_addr == 3'd6) m_ctrl = cfg_wdata[0];
    end
    for (int i = 0; i < 24; i++) begin
      m_ep[i] = ep_n[i];
      m_prev[i] = irq[i];
    end
  endtask

  // One clock: check the read port, clock, check outputs, drop pulses.
  task automatic step();
    #1;
    chk("rdata", int'(cfg_rdata), m_read(cfg_addr));
    @(posedge clk);
    model_step();
    #1;
    chk("int_req", int'(int_req), int'(m_req));
    chk("in_service", int'(in_service), int'(m_svc));
    chk("int_vector", int'(int_vector), m_vec);
    cfg_write = 0; int_ack = 0; int_eoi = 0; rst = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    cfg_write = 1; cfg_addr = a; cfg_wdata = d;
    step();
  endtask

  initial begin
    model_reset();
    irq = 24'h000013;
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1;
    step();
    chk("rst_req", int'(int_req), 0);
    chk("rst_svc", int'(in_service), 0);
    cfg_addr = 3'd4; #1;
    chk("rst_pend_level", int'(cfg_rdata), 'h013);
    irq = '0;
    step();

    // Edge interrupt on line 0 with two-edge latency.
    wr(3'd0, 12'h001); wr(3'd2, 12'h001); wr(3'd6, 12'h001);
    irq[0] = 1; step();
    chk("edge_req_k", int'(int_req), 0);
    irq[0] = 0; step();
    chk("edge_req_k1", int'(int_req), 1);
    chk("edge_vec", int'(int_vector), 0);
    int_ack = 1; step();
    chk("edge_svc", int'(in_service), 1);
    cfg_addr = 3'd4; #1;
    chk("edge_pend_clr", int'(cfg_rdata), 0);
    int_eoi = 1; step();
    chk("edge_idle", int'(in_service), 0);
    step();

    // Priority between two level lines.
    wr(3'd2, 12'h000); wr(3'd0, 12'h020); wr(3'd1, 12'h020);
    irq[5] = 1; irq[17] = 1; step();
    chk("prio_vec5", int'(int_vector), 5);
    int_ack = 1; step();
    irq[5] = 0; int_eoi = 1; step();
    step();
    chk("prio_req17", int'(int_req), 1);
    chk("prio_vec17", int'(int_vector), 17);
    int_ack = 1; step();
    irq[17] = 0; int_eoi = 1; step();

    // Withdrawal by masking before ack.
    wr(3'd1, 12'h000);
    irq[3] = 1; wr(3'd0, 12'h008); step();
    chk("wd_req", int'(int_req), 1);
    chk("wd_vec", int'(int_vector), 3);
    wr(3'd0, 12'h000); step();
    chk("wd_drop", int'(int_req), 0);
    irq[3] = 0; step();

    // Same-cycle edge set and write-1-clear.
    wr(3'd2, 12'h004);
    irq[2] = 1; wr(3'd4, 12'h004);
    cfg_addr = 3'd4; #1;
    chk("set_beats_clr", int'(cfg_rdata[2]), 1);
    wr(3'd4, 12'h004);
    irq[2] = 0; step();

    // No nesting: line 1 edge during service of line 9.
    wr(3'd2, 12'h206); wr(3'd0, 12'h202);
    irq[9] = 1; step();
    irq[9] = 0; step();
    chk("nest_vec9", int'(int_vector), 9);
    int_ack = 1; step();
    irq[1] = 1; step();
    irq[1] = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("nest_noreq", int'(int_req), 0);
    end
    int_eoi = 1; step();
    step();
    chk("nest_req1", int'(int_req), 1);
    chk("nest_vec1", int'(int_vector), 1);

    // Reset in the middle of service.
    int_ack = 1; step();
    chk("mid_svc", int'(in_service), 1);
    rst = 1; step();
    chk("mid_rst_svc", int'(in_service), 0);
    chk("mid_rst_req", int'(int_req), 0);
    cfg_addr = 3'd0; #1;
    chk("mid_rst_mask", int'(cfg_rdata), 0);
    int_eoi = 1; step();
    chk("stray_eoi", int'(in_service), 0);

    // Random traffic, including lines above NUM_IRQ.
    wr(3'd6, 12'h001);
    for (int c = 0; c < 3000; c++) begin
      irq = irq ^ ($urandom() & $urandom() & $urandom() & 32'h00FFFFFF);
      cfg_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        cfg_write = 1;
        cfg_wdata = 12'($urandom());
        if (cfg_addr == 3'd6 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
      end
      int_ack = (int_req && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0;
      int_eoi = (in_service && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
